// File: rtl/signed_mac_packed_acc.sv
// Signed multiply-accumulate over packed lanes.
// Mode 0: two 8bx8b lanes into ACC_W88-bit saturating accumulators.
// Mode 1: four 1bx8b lanes into ACC_W18-bit saturating accumulators.
// Beats flow through a MUL_LAT-deep product pipeline into the accumulators.
// A group closes on in_last or on the MAX_BEATS-th beat, and its result is held until taken.
module signed_mac_packed_acc #(
   parameter int unsigned HEADROOM  = 8,
   parameter int unsigned MUL_LAT   = 2,
   parameter int unsigned MAX_BEATS = 1024,
   localparam int unsigned CNT_W    = $clog2(MAX_BEATS) + 1,
   localparam int unsigned ACC_W88  = 16 + HEADROOM,
   localparam int unsigned ACC_W18  = 8 + HEADROOM,
   localparam int unsigned OUT_W    = (2 * ACC_W88 > 4 * ACC_W18) ? 2 * ACC_W88 : 4 * ACC_W18
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic             mode,
   input  logic [15:0]      act,
   input  logic [7:0]       wgt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_mode,
   output logic             out_sat,
   output logic [CNT_W-1:0] out_cnt
);

   // One guard bit above the widest accumulator so a single add cannot wrap.
   localparam int unsigned SUM_W = ACC_W88 + 1;
   localparam int unsigned LAST  = MUL_LAT - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

   localparam logic signed [SUM_W-1:0] MAX88 = {2'b00, {(ACC_W88 - 1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN88 = {2'b11, {(ACC_W88 - 1){1'b0}}};
   localparam logic signed [SUM_W-1:0] MAX18 =
      {{(SUM_W - ACC_W18 + 1){1'b0}}, {(ACC_W18 - 1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN18 =
      {{(SUM_W - ACC_W18 + 1){1'b1}}, {(ACC_W18 - 1){1'b0}}};

   // Input side
   logic                    en;
   logic                    accept;
   logic                    eff_mode;
   logic                    close_in;
   logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
   logic                    in_mode_q, in_mode_d;
   logic signed [7:0]       act0_s, act1_s, wgt_s;
   logic signed [15:0]      mul0, mul1;
   logic [3:0][15:0]        prod;

   // Product pipeline
   logic [MUL_LAT-1:0]             pv_q;
   logic [MUL_LAT-1:0]             plast_q;
   logic [MUL_LAT-1:0]             pmode_q;
   logic [MUL_LAT-1:0][3:0][15:0]  pprod_q;

   // Accumulation and result
   logic [3:0][ACC_W88-1:0]  acc_q, acc_nx;
   logic signed [SUM_W-1:0]  sum [4];
   logic signed [SUM_W-1:0]  hi, lo;
   logic [3:0]               clip;
   logic                     sat_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [OUT_W-1:0]         pack;
   logic                     upd, load;

   logic                     out_valid_q;
   logic [OUT_W-1:0]         out_data_q;
   logic                     out_mode_q;
   logic                     out_sat_q;
   logic [CNT_W-1:0]         out_cnt_q;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = reset_n && en;
   assign accept   = in_valid && in_ready;

   // The first beat of a group fixes its mode; later beats inherit it.
   assign eff_mode = (in_cnt_q == '0) ? mode : in_mode_q;
   assign close_in = in_last || (in_cnt_q == CNT_LAST);

   assign act0_s = act[7:0];
   assign act1_s = act[15:8];
   assign wgt_s  = wgt;
   assign mul0   = act0_s * wgt_s;
   assign mul1   = act1_s * wgt_s;

   // Lane products for the beat being offered, in the group's effective mode.
   always_comb begin
      prod = '0;
      if (!eff_mode) begin
         prod[0] = mul0;
         prod[1] = mul1;
      end else begin
         prod[0] = wgt[0] ? {{8{act[7]}}, act[7:0]}   : 16'h0000;
         prod[1] = wgt[0] ? {{8{act[15]}}, act[15:8]} : 16'h0000;
         prod[2] = wgt[1] ? {{8{act[7]}}, act[7:0]}   : 16'h0000;
         prod[3] = wgt[1] ? {{8{act[15]}}, act[15:8]} : 16'h0000;
      end
   end

   // Input-side beat counter decides group boundaries ahead of the pipeline.
   always_comb begin
      in_cnt_d  = in_cnt_q;
      in_mode_d = in_mode_q;
      if (accept) begin
         in_cnt_d  = close_in ? '0 : in_cnt_q + CNT_W'(1);
         in_mode_d = eff_mode;
      end
   end

   // Product pipeline and input-side group state; everything freezes when en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv_q      <= '0;
         plast_q   <= '0;
         pmode_q   <= '0;
         pprod_q   <= '0;
         in_cnt_q  <= '0;
         in_mode_q <= 1'b0;
      end else if (en) begin
         pv_q[0]    <= accept;
         plast_q[0] <= close_in;
         pmode_q[0] <= eff_mode;
         pprod_q[0] <= prod;
         for (int k = 1; k < MUL_LAT; k++) begin
            pv_q[k]    <= pv_q[k-1];
            plast_q[k] <= plast_q[k-1];
            pmode_q[k] <= pmode_q[k-1];
            pprod_q[k] <= pprod_q[k-1];
         end
         in_cnt_q  <= in_cnt_d;
         in_mode_q <= in_mode_d;
      end
   end

   // Saturating add of the pipeline's last stage onto each lane accumulator.
   always_comb begin
      hi     = pmode_q[LAST] ? MAX18 : MAX88;
      lo     = pmode_q[LAST] ? MIN18 : MIN88;
      clip   = '0;
      acc_nx = '0;
      for (int l = 0; l < 4; l++) begin
         sum[l] = $signed({acc_q[l][ACC_W88-1], acc_q[l]})
                + $signed({{(SUM_W - 16){pprod_q[LAST][l][15]}}, pprod_q[LAST][l]});
         if (sum[l] > hi) begin
            acc_nx[l] = hi[ACC_W88-1:0];
            clip[l]   = 1'b1;
         end else if (sum[l] < lo) begin
            acc_nx[l] = lo[ACC_W88-1:0];
            clip[l]   = 1'b1;
         end else begin
            acc_nx[l] = sum[l][ACC_W88-1:0];
         end
      end
   end

   // Pack the final lane values of the closing group.
   always_comb begin
      pack = '0;
      if (!pmode_q[LAST]) begin
         for (int i = 0; i < 2; i++) pack[i*ACC_W88 +: ACC_W88] = acc_nx[i];
      end else begin
         for (int j = 0; j < 4; j++) pack[j*ACC_W18 +: ACC_W18] = acc_nx[j][ACC_W18-1:0];
      end
   end

   assign upd  = en && pv_q[LAST];
   assign load = upd && plast_q[LAST];

   // Accumulators, group flags and the held result register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q       <= '0;
         sat_q       <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= 1'b0;
         out_sat_q   <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         if (upd) begin
            if (plast_q[LAST]) begin
               acc_q      <= '0;
               sat_q      <= 1'b0;
               cnt_q      <= '0;
               out_data_q <= pack;
               out_mode_q <= pmode_q[LAST];
               out_sat_q  <= sat_q || (|clip);
               out_cnt_q  <= cnt_q + CNT_W'(1);
            end else begin
               acc_q <= acc_nx;
               sat_q <= sat_q || (|clip);
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         // A fresh result loading on the handshake edge keeps out_valid high.
         if (load) begin
            out_valid_q <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;
   assign out_sat   = out_sat_q;
   assign out_cnt   = out_cnt_q;

endmodule
